csh_dir: RTL and testbench

- Cache directory for the MBOX cache.
- Holds a 4-way tag store plus per-line valid bits, indexed by physical address.
- On each lookup it produces the per-way VALID_MATCH vector and the address-parity-bad flag consumed by the cache select stage (CSH.VALID_MATCH[0:3], MBOX.CSH_ADR_PAR_BAD).
- Also services line fills, single-line invalidates and a full-cache clear sweep.

---
 rtl/csh_dir_pkg.sv | 35 +++
 rtl/csh_dir_way.sv | 37 +++
 rtl/csh_dir.sv | 120 ++++++++++++
 tb/tb_csh_dir.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csh_dir_pkg.sv
// MBOX cache directory shared types and constants.
// PA field helpers and the sweep state encoding live here.
package csh_dir_pkg;

    localparam int CSH_WAYS = 4;
    localparam int CSH_SETS = 128;
    localparam int CSH_TAGW = 13;
    localparam int CSH_IDXW = $clog2(CSH_SETS);
    localparam int CSH_WAYW = $clog2(CSH_WAYS);
    localparam int CSH_PAW  = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    function automatic logic [CSH_TAGW-1:0] pa_tag(input logic [CSH_PAW-1:0] pa);
        return pa[21:9];
    endfunction

    function automatic logic [CSH_IDXW-1:0] pa_idx(input logic [CSH_PAW-1:0] pa);
        return pa[8:2];
    endfunction

    function automatic logic [1:0] pa_word(input logic [CSH_PAW-1:0] pa);
        return pa[1:0];
    endfunction

    // True when two or more bits are set.
    function automatic logic multi_set(input logic [CSH_WAYS-1:0] v);
        return |(v & (v - 1'b1));
    endfunction

endpackage

// File: rtl/csh_dir_way.sv
// One way of the cache directory: tag array plus valid bits.
// Valid bits reset asynchronously; the tag array is never reset.
module csh_dir_way
    import csh_dir_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [CSH_IDXW-1:0] wr_idx_i,
    input  logic [CSH_TAGW-1:0] wr_tag_i,
    input  logic                clr_en_i,
    input  logic [CSH_IDXW-1:0] clr_idx_i,
    input  logic [CSH_IDXW-1:0] rd_idx_i,
    input  logic [CSH_TAGW-1:0] rd_tag_i,
    output logic                hit_o
);

    logic [CSH_TAGW-1:0] tag_q [CSH_SETS];
    logic [CSH_SETS-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;
    end

    // Write and clear never coincide: arbitration allows one op per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            if (clr_en_i) vld_q[clr_idx_i] <= 1'b0;
            if (wr_en_i)  vld_q[wr_idx_i]  <= 1'b1;
        end
    end

    assign hit_o = vld_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/csh_dir.sv
// MBOX cache directory: 4-way tag/valid store with lookup,
// fill, single-line invalidate and full clear sweep.
module csh_dir
    import csh_dir_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lookup_req,
    input  logic [CSH_PAW-1:0]  lookup_pa,
    input  logic                lookup_par,
    output logic                lookup_gnt,
    output logic                match_vld,
    output logic [CSH_WAYS-1:0] valid_match,
    output logic                multi_hit,
    output logic                adr_par_bad,
    input  logic                fill_req,
    input  logic [CSH_WAYW-1:0] fill_way,
    input  logic [CSH_PAW-1:0]  fill_pa,
    output logic                fill_gnt,
    input  logic                inval_req,
    input  logic [CSH_WAYW-1:0] inval_way,
    input  logic [CSH_IDXW-1:0] inval_idx,
    output logic                inval_gnt,
    input  logic                sweep_start,
    output logic                sweep_busy,
    output logic                sweep_done
);

    localparam logic [CSH_IDXW-1:0] LAST_IDX = CSH_IDXW'(CSH_SETS - 1);

    sweep_state_e        state_q, state_d;
    logic [CSH_IDXW-1:0] cnt_q, cnt_d;
    logic                sweep_clr;
    logic                sweep_go;
    logic                blk;
    logic [CSH_WAYS-1:0] hit;

    logic                match_vld_q;
    logic [CSH_WAYS-1:0] valid_match_q;
    logic                multi_hit_q;
    logic                adr_par_bad_q;

    logic                fill_word_unused;
    assign fill_word_unused = ^pa_word(fill_pa);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sweep_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                sweep_clr = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A sweep being started this cycle outranks every other request.
    assign sweep_go   = (state_q == IDLE) && sweep_start;
    assign blk        = (state_q == SWEEP) || sweep_go;
    assign fill_gnt   = rst_n && fill_req && !blk;
    assign inval_gnt  = rst_n && inval_req && !blk && !fill_req;
    assign lookup_gnt = rst_n && lookup_req && !blk && !fill_req && !inval_req;

    for (genvar w = 0; w < CSH_WAYS; w++) begin : g_way
        csh_dir_way u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (fill_gnt && (fill_way == CSH_WAYW'(w))),
            .wr_idx_i  (pa_idx(fill_pa)),
            .wr_tag_i  (pa_tag(fill_pa)),
            .clr_en_i  (sweep_clr || (inval_gnt && (inval_way == CSH_WAYW'(w)))),
            .clr_idx_i (sweep_clr ? cnt_q : inval_idx),
            .rd_idx_i  (pa_idx(lookup_pa)),
            .rd_tag_i  (pa_tag(lookup_pa)),
            .hit_o     (hit[w])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vld_q   <= 1'b0;
            valid_match_q <= '0;
            multi_hit_q   <= 1'b0;
            adr_par_bad_q <= 1'b0;
        end else begin
            match_vld_q   <= lookup_gnt;
            valid_match_q <= lookup_gnt ? hit : '0;
            multi_hit_q   <= lookup_gnt && multi_set(hit);
            adr_par_bad_q <= lookup_gnt && !((^lookup_pa) ^ lookup_par);
        end
    end

    assign match_vld   = match_vld_q;
    assign valid_match = valid_match_q;
    assign multi_hit   = multi_hit_q;
    assign adr_par_bad = adr_par_bad_q;
    assign sweep_busy  = (state_q == SWEEP);
    assign sweep_done  = (state_q == DONE);

endmodule

// File: tb/tb_csh_dir.sv
// Randomized and directed bench for csh_dir against a
// behavioural directory model held in plain arrays.
module tb_csh_dir;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_req;
    logic [21:0] lookup_pa;
    logic        lookup_par;
    logic        lookup_gnt;
    logic        match_vld;
    logic [3:0]  valid_match;
    logic        multi_hit;
    logic        adr_par_bad;
    logic        fill_req;
    logic [1:0]  fill_way;
    logic [21:0] fill_pa;
    logic        fill_gnt;
    logic        inval_req;
    logic [1:0]  inval_way;
    logic [6:0]  inval_idx;
    logic        inval_gnt;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;

    csh_dir dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_req  (lookup_req),
        .lookup_pa   (lookup_pa),
        .lookup_par  (lookup_par),
        .lookup_gnt  (lookup_gnt),
        .match_vld   (match_vld),
        .valid_match (valid_match),
        .multi_hit   (multi_hit),
        .adr_par_bad (adr_par_bad),
        .fill_req    (fill_req),
        .fill_way    (fill_way),
        .fill_pa     (fill_pa),
        .fill_gnt    (fill_gnt),
        .inval_req   (inval_req),
        .inval_way   (inval_way),
        .inval_idx   (inval_idx),
        .inval_gnt   (inval_gnt),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          mvalid [4][128];
    logic [12:0] mtag   [4][128];
    int          sweep_left = 0;
    bit          done_pend  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [21:0] mk_pa(input logic [12:0] t, input logic [6:0] i,
                                          input logic [1:0] w);
        return {t, i, w};
    endfunction

    function automatic logic good_par(input logic [21:0] pa);
        return ~(^pa);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 128; s++) mvalid[w][s] = 1'b0;
        sweep_left = 0;
        done_pend  = 1'b0;
    endtask

    task automatic idle_in();
        lookup_req  = 0; lookup_pa = '0; lookup_par = 0;
        fill_req    = 0; fill_way  = '0; fill_pa    = '0;
        inval_req   = 0; inval_way = '0; inval_idx  = '0;
        sweep_start = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {lookup_gnt, match_vld, valid_match, multi_hit, adr_par_bad,
               fill_gnt, inval_gnt, sweep_busy, sweep_done}, '0);
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic step();
        bit busy, go, blk, fg, ig, lg;
        logic [3:0] evm;
        bit emh, ebad;
        logic [6:0] li;
        busy = sweep_left > 0;
        go   = !busy && !done_pend && sweep_start;
        blk  = busy || go;
        fg   = fill_req && !blk;
        ig   = inval_req && !blk && !fill_req;
        lg   = lookup_req && !blk && !fill_req && !inval_req;
        #1;
        check("fill_gnt",   fill_gnt,   fg);
        check("inval_gnt",  inval_gnt,  ig);
        check("lookup_gnt", lookup_gnt, lg);
        check("sweep_busy", sweep_busy, busy);
        check("sweep_done", sweep_done, done_pend);
        evm = '0;
        li  = lookup_pa[8:2];
        if (lg)
            for (int w = 0; w < 4; w++)
                evm[w] = mvalid[w][li] && (mtag[w][li] == lookup_pa[21:9]);
        emh  = lg && ($countones(evm) > 1);
        ebad = lg && (((^lookup_pa) ^ lookup_par) == 1'b0);
        @(posedge clk);
        if (busy) begin
            for (int w = 0; w < 4; w++) mvalid[w][128 - sweep_left] = 1'b0;
            sweep_left--;
            done_pend = (sweep_left == 0);
        end else if (done_pend) begin
            done_pend = 1'b0;
        end else if (go) begin
            sweep_left = 128;
        end
        if (fg) begin
            mtag[fill_way][fill_pa[8:2]]   = fill_pa[21:9];
            mvalid[fill_way][fill_pa[8:2]] = 1'b1;
        end
        if (ig) mvalid[inval_way][inval_idx] = 1'b0;
        #1;
        check("match_vld",   match_vld,   lg);
        check("valid_match", valid_match, evm);
        check("multi_hit",   multi_hit,   emh);
        check("adr_par_bad", adr_par_bad, ebad);
        @(negedge clk);
    endtask

    task automatic do_fill(input logic [1:0] w, input logic [21:0] pa);
        idle_in(); fill_req = 1; fill_way = w; fill_pa = pa;
        step(); idle_in();
    endtask

    task automatic do_inval(input logic [1:0] w, input logic [6:0] i);
        idle_in(); inval_req = 1; inval_way = w; inval_idx = i;
        step(); idle_in();
    endtask

    task automatic do_lookup(input logic [21:0] pa, input logic par);
        idle_in(); lookup_req = 1; lookup_pa = pa; lookup_par = par;
        step(); idle_in();
    endtask

    task automatic run_sweep(input int rst_at, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        idle_in(); sweep_start = 1; step(); idle_in();
        for (int c = 0; c < 200; c++) begin
            if (c == rst_at) begin
                rst_n = 0;
                #1;
                check_all_zero("rst_mid_sweep");
                model_reset();
                @(negedge clk);
                rst_n = 1;
                break;
            end
            if (sweep_busy) busy_n++;
            if (sweep_done) done_n++;
            lookup_req = 1; lookup_pa = mk_pa(13'h0aaa, 7'd0, 2'd0);
            lookup_par = good_par(lookup_pa);
            if (sweep_done) begin
                step();
                break;
            end
            step();
        end
        idle_in();
    endtask

    logic [21:0] pa;
    int          bn, dn;
    logic [12:0] tags [4];
    logic [6:0]  idxs [4];

    initial begin
        idle_in();
        rst_n = 0;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        pa = 22'h012345;
        do_lookup(pa, good_par(pa));
        check("rst_lu_vm",  valid_match, 4'b0000);
        check("rst_lu_bad", adr_par_bad, 1'b0);
        check("rst_lu_vld", match_vld,   1'b1);

        do_fill(2'd2, 22'h3ABCD4);
        do_lookup(22'h3ABCD4, good_par(22'h3ABCD4));
        check("hit_w2_vm", valid_match, 4'b0100);
        check("hit_w2_mh", multi_hit,   1'b0);
        do_lookup(22'h1ABCD4, good_par(22'h1ABCD4));
        check("tag_miss_vm", valid_match, 4'b0000);

        do_lookup(22'h000001, 1'b1);
        check("par_bad", adr_par_bad, 1'b1);
        do_lookup(22'h000001, 1'b0);
        check("par_good", adr_par_bad, 1'b0);

        pa = 22'h2468AC;
        do_fill(2'd0, pa);
        do_fill(2'd3, pa);
        do_lookup(pa, good_par(pa));
        check("multi_vm", valid_match, 4'b1001);
        check("multi_mh", multi_hit,   1'b1);
        do_inval(2'd0, pa[8:2]);
        do_lookup(pa, good_par(pa));
        check("inval_vm", valid_match, 4'b1000);
        check("inval_mh", multi_hit,   1'b0);

        pa = 22'h155554;
        idle_in();
        fill_req = 1; fill_way = 2'd1; fill_pa = pa;
        lookup_req = 1; lookup_pa = pa; lookup_par = good_par(pa);
        #1;
        check("prio_fill_gnt", fill_gnt,   1'b1);
        check("prio_lu_gnt",   lookup_gnt, 1'b0);
        step();
        fill_req = 0;
        step();
        check("prio_lu_hit", valid_match, 4'b0010);
        idle_in();

        do_fill(2'd0, mk_pa(13'h0aaa, 7'd0,   2'd0));
        do_fill(2'd1, mk_pa(13'h1bbb, 7'd0,   2'd1));
        do_fill(2'd2, mk_pa(13'h0ccc, 7'd127, 2'd2));
        do_fill(2'd3, mk_pa(13'h1ddd, 7'd127, 2'd3));
        run_sweep(-1, bn, dn);
        check("sweep_busy_cycles", bn, 128);
        check("sweep_done_pulses", dn, 1);
        do_lookup(mk_pa(13'h0aaa, 7'd0, 2'd0), 1'b0);
        check("swp_l0", valid_match, 4'b0000);
        do_lookup(mk_pa(13'h1bbb, 7'd0, 2'd0), 1'b0);
        check("swp_l1", valid_match, 4'b0000);
        do_lookup(mk_pa(13'h0ccc, 7'd127, 2'd0), 1'b0);
        check("swp_l2", valid_match, 4'b0000);
        do_lookup(mk_pa(13'h1ddd, 7'd127, 2'd0), 1'b0);
        check("swp_l3", valid_match, 4'b0000);

        do_fill(2'd1, mk_pa(13'h0aaa, 7'd127, 2'd0));
        run_sweep(50, bn, dn);
        check("rst_sweep_done", dn, 0);
        for (int c = 0; c < 4; c++) step();
        check("rst_sweep_idle", sweep_busy, 1'b0);

        for (int i = 0; i < 4; i++) tags[i] = 13'($urandom);
        tags[0] = 13'h1d5e;
        idxs[0] = 7'd0; idxs[1] = 7'd127; idxs[2] = 7'd5; idxs[3] = 7'($urandom);
        for (int i = 0; i < 3000; i++) begin
            idle_in();
            fill_req    = ($urandom_range(0, 5) == 0);
            fill_way    = 2'($urandom);
            fill_pa     = mk_pa(tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)],
                                2'($urandom));
            inval_req   = ($urandom_range(0, 7) == 0);
            inval_way   = 2'($urandom);
            inval_idx   = idxs[$urandom_range(0, 3)];
            lookup_req  = ($urandom_range(0, 2) != 0);
            lookup_pa   = mk_pa(tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)],
                                2'($urandom));
            lookup_par  = ($urandom_range(0, 4) == 0) ? ~good_par(lookup_pa)
                                                      : good_par(lookup_pa);
            sweep_start = ($urandom_range(0, 599) == 0);
            step();
        end
        idle_in();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
